// File: rtl/axi_wr_path_arbiter.sv
// Purpose : round-robin arbiter sharing one AXI slave write path (AW, W, B) among NUM_M masters,
//           holding one complete write transaction (address, all data beats, response) at a time.
// Latency : 1 cycle from m_awvalid to s_awvalid; AW/W/B handshakes are combinational passthrough once granted.
// Backpr. : slave ready/valid goes straight back to the granted master; other masters see ready=0, bvalid=0.
//
// Ports:
//   clk, resetn                        clock, asynchronous active-low reset
//   m_aw*/m_w*/m_b*                    per-master AXI write channels (packed AW payload in m_aw_info)
//   s_aw*/s_w*/s_b*                    single downstream slave write channels
//   grant_idx, busy                    granted master (meaningful while busy), busy = not idle
//   err_wlast                          one-cycle pulse after a W beat whose WLAST disagrees with awlen
//
// AW payload layout, MSB first: {awid, awaddr[31:0], awlen[7:0], awlock, awsize, awburst, awcache,
// awprot, awqos, awregion}; awlen therefore sits 44 bits below the top of the payload.

module axi_wr_path_arbiter #(
  parameter int NUM_M     = 4,
  parameter int AW_INFO_W = 65,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  localparam int GW       = (NUM_M > 1) ? $clog2(NUM_M) : 1,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_M-1:0]            m_awvalid,
  input  logic [NUM_M*AW_INFO_W-1:0]  m_aw_info,
  output logic [NUM_M-1:0]            m_awready,
  input  logic [NUM_M-1:0]            m_wvalid,
  input  logic [NUM_M*DATA_W-1:0]     m_wdata,
  input  logic [NUM_M*STRB_W-1:0]     m_wstrb,
  input  logic [NUM_M-1:0]            m_wlast,
  output logic [NUM_M-1:0]            m_wready,
  output logic [ID_W-1:0]             m_bid,
  output logic [1:0]                  m_bresp,
  output logic [NUM_M-1:0]            m_bvalid,
  input  logic [NUM_M-1:0]            m_bready,
  output logic                        s_awvalid,
  output logic [AW_INFO_W-1:0]        s_aw_info,
  input  logic                        s_awready,
  output logic                        s_wvalid,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [STRB_W-1:0]           s_wstrb,
  output logic                        s_wlast,
  input  logic                        s_wready,
  input  logic [ID_W-1:0]             s_bid,
  input  logic [1:0]                  s_bresp,
  input  logic                        s_bvalid,
  output logic                        s_bready,
  output logic [GW-1:0]               grant_idx,
  output logic                        busy,
  output logic                        err_wlast
);

  localparam int AWLEN_LSB = AW_INFO_W - 44;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [7:0]      len_q;
  logic [7:0]      beat_cnt_q;
  logic            err_q;

  logic            pick_vld;
  logic [GW-1:0]   pick_idx;
  logic [AW_INFO_W-1:0] aw_info_g;
  logic            aw_hs, w_hs, b_hs;

  // First requester at or above rr_ptr, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (!pick_vld && m_awvalid[(int'(rr_ptr_q) + k) % NUM_M]) begin
        pick_vld = 1'b1;
        pick_idx = GW'((int'(rr_ptr_q) + k) % NUM_M);
      end
    end
  end

  assign aw_info_g = m_aw_info[int'(grant_q)*AW_INFO_W +: AW_INFO_W];
  assign aw_hs     = (state_q == ADDR) && m_awvalid[grant_q] && s_awready;
  assign w_hs      = (state_q == DATA) && m_wvalid[grant_q]  && s_wready;
  assign b_hs      = (state_q == RESP) && s_bvalid && m_bready[grant_q];

  // Channel muxing: everything outside the active phase is forced to zero.
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bid     = '0;
    m_bresp   = '0;
    s_awvalid = 1'b0;
    s_aw_info = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wlast   = 1'b0;
    s_bready  = 1'b0;
    case (state_q)
      ADDR: begin
        s_awvalid          = m_awvalid[grant_q];
        s_aw_info          = aw_info_g;
        m_awready[grant_q] = s_awready;
      end
      DATA: begin
        s_wvalid          = m_wvalid[grant_q];
        s_wdata           = m_wdata[int'(grant_q)*DATA_W +: DATA_W];
        s_wstrb           = m_wstrb[int'(grant_q)*STRB_W +: STRB_W];
        s_wlast           = m_wlast[grant_q];
        m_wready[grant_q] = s_wready;
      end
      RESP: begin
        m_bvalid[grant_q] = s_bvalid;
        m_bid             = s_bid;
        m_bresp           = s_bresp;
        s_bready          = m_bready[grant_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            len_q      <= aw_info_g[AWLEN_LSB +: 8];
            beat_cnt_q <= '0;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            // beat_cnt_q is the index of the beat being accepted; awlen names the last index.
            beat_cnt_q <= (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
            if (m_wlast[grant_q]) begin
              err_q   <= (beat_cnt_q != len_q);
              state_q <= RESP;
            end else begin
              err_q <= (beat_cnt_q == len_q);
            end
          end
        end
        RESP: begin
          if (b_hs) begin
            rr_ptr_q <= (int'(grant_q) == NUM_M - 1) ? '0 : grant_q + 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q != IDLE);
  assign err_wlast = err_q;

endmodule

// File: tb/tb_axi_wr_path_arbiter.sv
module tb_axi_wr_path_arbiter;

  localparam int NM  = 4;
  localparam int AIW = 65;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int SW  = DW / 8;
  localparam int AWLEN_LSB = AIW - 44;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NM-1:0]    m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic [NM*AIW-1:0] m_aw_info;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_wstrb;
  logic [IW-1:0]    m_bid, s_bid;
  logic [1:0]       m_bresp, s_bresp;
  logic             s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [AIW-1:0]   s_aw_info;
  logic [DW-1:0]    s_wdata;
  logic [SW-1:0]    s_wstrb;
  logic [1:0]       grant_idx;
  logic             busy, err_wlast;
  logic [126:0]     all_outs;

  axi_wr_path_arbiter dut (
    .clk(clk), .resetn(resetn),
    .m_awvalid(m_awvalid), .m_aw_info(m_aw_info), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_awvalid(s_awvalid), .s_aw_info(s_aw_info), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant_idx(grant_idx), .busy(busy), .err_wlast(err_wlast)
  );

  always #5 clk = ~clk;

  assign all_outs = {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_wlast, s_bready, busy,
                     err_wlast, grant_idx, s_aw_info, s_wdata, s_wstrb, m_bid, m_bresp};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending requests, per-master transaction shape, round-robin pointer.
  logic [NM-1:0]  req;
  logic [AIW-1:0] info_a [NM];
  int             len_a  [NM];
  int             nb_a   [NM];
  int             ptr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NM-1:0] r, input int p);
    for (int k = 0; k < NM; k++)
      if (r[(p + k) % NM]) return (p + k) % NM;
    return -1;
  endfunction

  task automatic raise(input int m, input int len, input int nb);
    logic [AIW-1:0] v;
    v = AIW'({$urandom, $urandom, $urandom});
    v[AWLEN_LSB +: 8] = len[7:0];
    info_a[m] = v;
    len_a[m]  = len;
    nb_a[m]   = nb;
    m_aw_info[m*AIW +: AIW] = v;
    req[m]    = 1'b1;
    m_awvalid = req;
  endtask

  task automatic clear_inputs();
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
    m_wvalid = '0; m_wlast = '0; m_bready = '0;
  endtask

  // Runs one full transaction for whichever master the model says wins. Entered and left
  // just after a falling edge; abort_at >= 0 returns inside DATA after that many beats.
  task automatic serve(input int aw_stall, input bit toggle, input int bdly, input int abort_at);
    int m, w, b, cyc, len, nb;
    logic [NM-1:0] oh;
    logic [DW-1:0] d;
    logic [SW-1:0] st;
    logic last, ebeat, hs;
    m = rr_pick(req, ptr);
    oh = '0; oh[m] = 1'b1;
    len = len_a[m]; nb = nb_a[m];
    w = 0;
    while (!busy && w < 20) begin @(negedge clk); #1; w++; end
    chk("grant_latency", 128'(w), 128'(1));
    if (!busy) begin
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "FAIL grant_wait timed out");
    end
    chk("grant_idx", 128'(grant_idx), 128'(m));
    chk("s_aw_info", 128'(s_aw_info), 128'(info_a[m]));
    for (int s = 0; s <= aw_stall; s++) begin
      s_awready = (s == aw_stall);
      m_wvalid[m] = 1'b1; s_wready = 1'b1;
      #1;
      chk("s_awvalid_held", 128'(s_awvalid), 128'(1));
      chk("m_awready", 128'(m_awready), 128'(s_awready ? oh : '0));
      chk("early_w_blocked", 128'({m_wready, s_wvalid}), 128'(0));
      @(negedge clk); #1;
    end
    s_awready = 1'b0;
    req[m] = 1'b0; m_awvalid = req;
    b = 0; cyc = 0;
    while (b < nb && cyc < 100) begin
      if (b == abort_at) return;
      last = (b == nb - 1);
      d = $urandom; st = SW'($urandom);
      m_wvalid[m] = 1'b1; m_wdata[m*DW +: DW] = d; m_wstrb[m*SW +: SW] = st; m_wlast[m] = last;
      s_wready = toggle ? (cyc % 2 == 0) : 1'b1;
      hs = s_wready;
      #1;
      chk("m_wready", 128'(m_wready), 128'(hs ? oh : '0));
      chk("s_wvalid", 128'(s_wvalid), 128'(1));
      ebeat = last ? (b != len) : (b == len);
      if (hs) begin
        chk("s_wbeat", 128'({s_wdata, s_wstrb, s_wlast}), 128'({d, st, last}));
        b++;
      end
      @(negedge clk); #1;
      chk("err_wlast", 128'(err_wlast), 128'(hs && ebeat));
      cyc++;
    end
    chk("beats_accepted", 128'(b), 128'(nb));
    m_wvalid = '0; m_wlast = '0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bid = IW'($urandom); s_bresp = 2'($urandom);
    for (int k = 0; k <= bdly; k++) begin
      m_bready = (k == bdly) ? oh : ~oh;
      #1;
      chk("resp_route", 128'({m_bvalid, m_bid, m_bresp}), 128'({oh, s_bid, s_bresp}));
      chk("s_bready", 128'(s_bready), 128'(k == bdly));
      chk("resp_busy_grant", 128'({busy, grant_idx}), 128'({1'b1, 2'(m)}));
      @(negedge clk); #1;
    end
    s_bvalid = 1'b0; m_bready = '0;
    ptr = (m + 1) % NM;
    #1;
    chk("idle_after_b", 128'({busy, m_bvalid}), 128'(0));
  endtask

  initial begin
    resetn = 1'b0; req = '0; ptr = 0;
    m_awvalid = '0; m_aw_info = '0; m_wdata = '0; m_wstrb = '0;
    clear_inputs();
    // Noise on every input while reset is held: outputs must stay zero.
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bid = '1; s_bresp = 2'b11;
    m_wvalid = '1; m_wlast = '1; m_bready = '1;
    @(negedge clk); @(negedge clk); #1;
    chk("reset_outputs", 128'(all_outs), 128'(0));
    for (int i = 0; i < NM; i++) raise(i, 0, 1);
    @(negedge clk); #1;
    chk("reset_outputs_with_req", 128'(all_outs), 128'(0));
    clear_inputs();
    resetn = 1'b1;

    // All four request together: rotation from master 0, then master 0 again.
    for (int i = 0; i < NM; i++) serve(0, 0, 0, -1);
    raise(0, 0, 1);
    serve(0, 0, 0, -1);

    // Single request from master 2, then pointer check via a 0/3 contest.
    raise(2, 3, 4);
    serve(0, 0, 0, -1);
    raise(0, 0, 1); raise(3, 0, 1);
    serve(0, 0, 0, -1);
    serve(0, 0, 0, -1);

    // AW stall of 5 cycles, then W ready toggling.
    raise(1, 2, 3);
    serve(5, 1, 1, -1);

    // Early WLAST, then missing WLAST.
    raise(2, 1, 1);
    serve(0, 0, 0, -1);
    raise(3, 0, 2);
    serve(0, 1, 0, -1);

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NM; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          int l;
          l = $urandom_range(0, 3);
          raise(i, l, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : l + 1);
        end
      end
      if (req == '0) raise($urandom_range(0, NM - 1), 1, 2);
      serve($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 1), -1);
    end
    while (req != '0) serve(0, 0, 0, -1);

    // Reset after beat 1 of 4: everything drops at once, pointer returns to 0.
    raise(1, 3, 4);
    serve(0, 0, 0, 2);
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; m_bready = '1; m_awvalid = '1;
    resetn = 1'b0;
    #1;
    chk("mid_reset_outputs", 128'(all_outs), 128'(0));
    @(negedge clk); @(negedge clk); #1;
    chk("mid_reset_hold", 128'(all_outs), 128'(0));
    clear_inputs();
    req = '0; m_awvalid = '0; ptr = 0;
    resetn = 1'b1;
    raise(0, 0, 1); raise(3, 0, 1);
    serve(0, 0, 0, -1);
    chk("post_reset_ptr", 128'(ptr), 128'(1));
    serve(0, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
